// File: rtl/multi_operand_adder.sv
// multi_operand_adder
//   Accumulates NUM_OPERANDS unsigned WIDTH-bit operands, one per accepted
//   input handshake. It then presents a single WIDTH-bit result with a carry
//   flag. In saturation mode an overflowing sum clamps to all-ones.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   clear           : synchronous abort of any partial or pending sum
//   in_valid/ready  : operand stream handshake; in_a is the operand
//   sat_en          : saturation mode, latched with the first operand of a group
//   out_valid/ready : result stream handshake
//   result          : wrapped or saturated sum
//   carry_out       : true sum exceeded 2**WIDTH-1
module multi_operand_adder #(
    parameter int WIDTH        = 4,
    parameter int NUM_OPERANDS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);

    // The accumulator is wide enough that NUM_OPERANDS max-value operands
    // never wrap, so carry is simply "any bit above WIDTH is set".
    localparam int AW = WIDTH + $clog2(NUM_OPERANDS);
    localparam int CW = $clog2(NUM_OPERANDS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(NUM_OPERANDS - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;

    logic             accept;
    logic [AW-1:0]    sum;
    logic             sum_carry;

    // in_ready is a pure state decode: no path from in_valid or out_ready.
    assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
    assign accept    = in_valid && in_ready;
    assign sum       = acc_q + AW'(in_a);
    assign sum_carry = |sum[AW-1:WIDTH];

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        carry_d     = carry_q;

        if (clear) begin
            // Abort wins over any handshake in the same cycle.
            state_d     = IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_d   = AW'(in_a);
                        cnt_d   = CW'(1);
                        sat_d   = sat_en;
                        state_d = ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_d = sum;
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == LAST_CNT) begin
                            carry_d     = sum_carry;
                            result_d    = (sat_q && sum_carry) ? {WIDTH{1'b1}}
                                                               : sum[WIDTH-1:0];
                            out_valid_d = 1'b1;
                            state_d     = DONE;
                        end
                    end
                end
                DONE: begin
                    // result/carry_out intentionally keep their values after
                    // the handshake; only out_valid drops.
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_multi_operand_adder.sv
// Directed testbench for multi_operand_adder (WIDTH=4, NUM_OPERANDS=4).
// Inputs change 1ns after a rising edge and outputs are sampled there too.
module tb_multi_operand_adder;

    logic       clk = 1'b0;
    logic       rst, clear, in_valid, sat_en, out_ready;
    logic       in_ready, out_valid, carry_out;
    logic [3:0] in_a, result;

    int checks   = 0;
    int failures = 0;

    multi_operand_adder #(.WIDTH(4), .NUM_OPERANDS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .sat_en    (sat_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][3:0] ops;
        logic            sat;
        logic [3:0]      exp_res;
        logic            exp_c;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand and wait (bounded) until it is accepted.
    task automatic offer(input logic [3:0] v, input logic s);
        int n = 0;
        in_valid = 1'b1;
        in_a     = v;
        sat_en   = s;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) chk("accept_timeout", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        sat_en   = 1'b0;
    endtask

    // sat_en is driven to the opposite level on later operands so that any
    // re-sampling after the first operand is visible in the result.
    task automatic send_group(input logic [3:0][3:0] ops, input logic s, input int gap);
        for (int i = 0; i < 4; i++) begin
            offer(ops[i], (i == 0) ? s : ~s);
            if (i < 3) begin
                chk("no_early_valid", 32'(out_valid), 32'd0);
                repeat (gap) step();
            end
        end
    endtask

    task automatic expect_out(input string name, input logic [3:0] r, input logic c);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_result"}, 32'(result), 32'(r));
        chk({name, "_carry"}, 32'(carry_out), 32'(c));
        chk({name, "_in_ready_done"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        // ops[0] is the first operand sent.
        vecs[0] = '{ops: {4'd4, 4'd3, 4'd2, 4'd1},     sat: 1'b0, exp_res: 4'd10, exp_c: 1'b0};
        vecs[1] = '{ops: {4'd15, 4'd15, 4'd15, 4'd15}, sat: 1'b0, exp_res: 4'd12, exp_c: 1'b1};
        vecs[2] = '{ops: {4'd15, 4'd15, 4'd15, 4'd15}, sat: 1'b1, exp_res: 4'd15, exp_c: 1'b1};
        vecs[3] = '{ops: {4'd0, 4'd1, 4'd7, 4'd7},     sat: 1'b0, exp_res: 4'd15, exp_c: 1'b0};
        vecs[4] = '{ops: {4'd1, 4'd1, 4'd7, 4'd7},     sat: 1'b0, exp_res: 4'd0,  exp_c: 1'b1};
        vecs[5] = '{ops: {4'd1, 4'd1, 4'd7, 4'd7},     sat: 1'b1, exp_res: 4'd15, exp_c: 1'b1};
        vecs[6] = '{ops: {4'd0, 4'd1, 4'd7, 4'd7},     sat: 1'b1, exp_res: 4'd15, exp_c: 1'b0};

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; sat_en = 1'b0;
        out_ready = 1'b1; in_a = '0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_carry", 32'(carry_out), 32'd0);
        step(); step();
        rst = 1'b0;
        step();

        // Table: back-to-back operands, consumer always ready.
        for (int v = 0; v < 7; v++) begin
            send_group(vecs[v].ops, vecs[v].sat, 0);
            expect_out($sformatf("vec%0d", v), vecs[v].exp_res, vecs[v].exp_c);
            step();
            chk("handshake_valid_low", 32'(out_valid), 32'd0);
            chk("handshake_in_ready", 32'(in_ready), 32'd1);
        end

        // Gaps of 2 idle cycles between operands.
        send_group({4'd4, 4'd3, 4'd2, 4'd1}, 1'b0, 2);
        expect_out("gaps", 4'd10, 1'b0);
        step();

        // Backpressure: result holds and no operand is consumed in DONE.
        out_ready = 1'b0;
        send_group({4'd1, 4'd5, 4'd4, 4'd3}, 1'b0, 0);
        in_valid = 1'b1; in_a = 4'd9;
        for (int i = 0; i < 3; i++) begin
            expect_out("bp_hold", 4'd13, 1'b0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        send_group({4'd1, 4'd1, 4'd1, 4'd1}, 1'b0, 0);
        expect_out("bp_next", 4'd4, 1'b0);
        step();

        // Clear mid-group, with an operand offered in the clear cycle.
        offer(4'd5, 1'b0);
        offer(4'd5, 1'b0);
        clear = 1'b1; in_valid = 1'b1; in_a = 4'd7;
        step();
        clear = 1'b0; in_valid = 1'b0;
        chk("clear_in_ready", 32'(in_ready), 32'd1);
        chk("clear_out_valid", 32'(out_valid), 32'd0);
        send_group({4'd1, 4'd1, 4'd1, 4'd1}, 1'b0, 0);
        expect_out("after_clear", 4'd4, 1'b0);
        step();

        // Clear while a result is pending.
        out_ready = 1'b0;
        send_group({4'd2, 4'd2, 4'd2, 4'd2}, 1'b0, 0);
        expect_out("pre_clear_done", 4'd8, 1'b0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_done_valid", 32'(out_valid), 32'd0);
        chk("clear_done_in_ready", 32'(in_ready), 32'd1);

        // Asynchronous reset in DONE, asserted mid-cycle.
        send_group({4'd15, 4'd15, 4'd15, 4'd15}, 1'b1, 0);
        expect_out("pre_rst", 4'd15, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_result", 32'(result), 32'd0);
        chk("async_rst_carry", 32'(carry_out), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        send_group({4'd4, 4'd3, 4'd2, 4'd1}, 1'b0, 0);
        expect_out("post_rst", 4'd10, 1'b0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multi_operand_adder.md
# multi_operand_adder

Sequential, parametrised successor to the two-input adder: accumulates a fixed number of `WIDTH`-bit operands arriving one per cycle on a valid/ready stream. It returns a single `WIDTH`-bit result with a carry flag and an optional saturation mode. The block sits between an operand producer and a result consumer, and both sides may apply backpressure.

## Interface
- `WIDTH`, default 4: operand and result width in bits; minimum 1.
- `NUM_OPERANDS`, default 4: operands summed per result; minimum 2.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `clear` input 1: synchronous abort; discards any partial or pending sum.
- `in_valid` input 1: `in_a` holds an operand.
- `in_ready` output 1: block accepts an operand this cycle.
- `in_a` input `WIDTH`: operand value, unsigned.
- `sat_en` input 1: saturation mode; sampled only when the first operand of a group is accepted.
- `out_valid` output 1: `result` and `carry_out` are valid.
- `out_ready` input 1: consumer takes the result this cycle.
- `result` output `WIDTH`: sum, wrapped or saturated.
- `carry_out` output 1: the true sum exceeded `MAX_VALUE = 2**WIDTH - 1`.

## Operation
- **Internal widths**
  - Accumulator width is `WIDTH + $clog2(NUM_OPERANDS)`. It never wraps internally.
  - Operand counter width is `$clog2(NUM_OPERANDS+1)`.
- **States:** `IDLE`, `ACCUM`, `DONE`.
- **`in_ready`** = (state is `IDLE` or `ACCUM`). It is a combinational state decode and is 1 in reset.
- **`IDLE`**, on accept (`in_valid && in_ready`):
  - acc <= zero-extended `in_a`; cnt <= 1; sat_q <= `sat_en`.
  - Go to `ACCUM`.
- **`ACCUM`**, on accept:
  - acc <= acc + `in_a`; cnt <= cnt + 1.
  - If this is the `NUM_OPERANDS`-th operand: register the outputs and go to `DONE`. Otherwise stay in `ACCUM`.
  - A cycle with no accept holds all state; gaps in the operand stream are allowed.
- **Output registration** (on accepting the last operand), with S the final true sum:
  - `carry_out` <= (S > `MAX_VALUE`).
  - `result` <= `MAX_VALUE` if sat_q and carry; otherwise S[`WIDTH`-1:0].
  - `out_valid` <= 1.
- **`DONE`**
  - `in_ready` = 0; `in_valid` is ignored.
  - `out_valid`, `result` and `carry_out` hold stable until `out_ready` = 1.
  - On handshake: `out_valid` <= 0 and state goes to `IDLE`. `result` and `carry_out` keep their last values.
- **`clear`**
  - Highest priority after `rst`. On any edge where it is sampled high: state <= `IDLE`, cnt <= 0, acc <= 0, `out_valid` <= 0.
  - Any `in_valid` in that cycle is not accepted, even though `in_ready` may read 1.
- **`rst`** (asserted at any time, including mid-group or in `DONE`):
  - Takes effect immediately.
  - state = `IDLE`; acc, cnt and sat_q = 0; `out_valid` = 0; `result` = 0; `carry_out` = 0; `in_ready` = 1.

## Timing
- The last operand is accepted at edge k; `out_valid` = 1 after edge k.
- Minimum group period is `NUM_OPERANDS` + 1 cycles: `NUM_OPERANDS` accepts plus one output cycle with `out_ready` held 1.
- The first operand of the next group can be accepted at the edge following the output handshake.
- No combinational path exists from `in_a`/`in_valid` to any output, or from `out_ready` to `in_ready`.
- The saturation and carry boundary is exactly S = `MAX_VALUE`: that sum gives carry 0. S = `MAX_VALUE` + 1 gives carry 1.

## Test plan
All scenarios use `WIDTH`=4 and `NUM_OPERANDS`=4.
- **Basic sum:** operands 1,2,3,4 back-to-back, `sat_en`=0, `out_ready`=1 → `out_valid` one cycle after the 4th accept, `result`=10, `carry_out`=0; `in_ready` back to 1 the next cycle.
- **Wrap:** 15,15,15,15, `sat_en`=0 → `result`=12 (60 mod 16), `carry_out`=1.
- **Saturate:** 15,15,15,15 with `sat_en`=1 on the first operand only → `result`=15, `carry_out`=1.
- **Carry boundary:** 7,7,1,0 gives `result`=15, `carry_out`=0. 7,7,1,1 gives `result`=0, `carry_out`=1.
- **Backpressure and gaps:**
  - Insert 2 idle cycles between operands: sum is unaffected.
  - Hold `out_ready`=0 for 3 cycles while driving `in_valid`=1 → `out_valid` stays 1, `result` is stable, `in_ready`=0, and no operand is consumed.
- **Abort and reset:**
  - `clear` after 2 operands, then 1,1,1,1 → `result`=4.
  - `rst` pulsed in `DONE` → `out_valid`, `result` and `carry_out` read 0 immediately, and `in_ready`=1.
